// File: rtl/quadrature_decoder_pkg.sv
// Shared definitions for the quadrature decoder and its bench model.
//   - qd_state_e : decoder FSM states (StInit, StRun)
//   - step_t     : signed 2-bit step (+1 / 0 / -1) with named constants
//   - GRAY_SEQ   : forward quadrature sequence {A,B}: 00 -> 01 -> 11 -> 10
//   - gray_pos   : position of a {A,B} pair within GRAY_SEQ
//   - gray_step  : step implied by a prev -> cur transition (illegal maps to 0)
package quadrature_decoder_pkg;

  typedef enum logic [0:0] {StInit, StRun} qd_state_e;

  typedef logic signed [1:0] step_t;

  localparam step_t STEP_FWD  = 2'sb01;
  localparam step_t STEP_NONE = 2'sb00;
  localparam step_t STEP_REV  = 2'sb11;

  localparam logic [1:0] GRAY_SEQ [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  function automatic logic [1:0] gray_pos(input logic [1:0] s);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (GRAY_SEQ[i] == s) idx = 2'(i);
    end
    return idx;
  endfunction

  // Distance along the sequence: 1 = forward, 3 = reverse, 0 = hold, 2 = both bits flipped.
  function automatic step_t gray_step(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] delta;
    step_t      step;
    delta = gray_pos(cur) - gray_pos(prev);
    case (delta)
      2'd1:    step = STEP_FWD;
      2'd3:    step = STEP_REV;
      default: step = STEP_NONE;
    endcase
    return step;
  endfunction

endpackage

// File: rtl/quadrature_decoder_if.sv
// Signal bundle between the encoder-side environment and quadrature_decoder.
//   master : drives enc_a, enc_b, clear, err_clr; observes decoder outputs
//   slave  : the decoder; observes inputs, drives position, velocity, vel_valid, dir, err
interface quadrature_decoder_if #(
  parameter int unsigned POS_WIDTH = 16,
  parameter int unsigned VEL_WIDTH = 8
);

  logic                 enc_a;
  logic                 enc_b;
  logic                 clear;
  logic                 err_clr;
  logic [POS_WIDTH-1:0] position;
  logic [VEL_WIDTH-1:0] velocity;
  logic                 vel_valid;
  logic                 dir;
  logic                 err;

  modport master (
    output enc_a, enc_b, clear, err_clr,
    input  position, velocity, vel_valid, dir, err
  );

  modport slave (
    input  enc_a, enc_b, clear, err_clr,
    output position, velocity, vel_valid, dir, err
  );

endinterface

// File: rtl/quadrature_decoder_enc_input_cond.sv
// Conditions one asynchronous encoder channel for use in the cclk domain.
// Two-flop synchronizer, optionally followed by a glitch filter when ENC_FILTER_EN is defined:
// the filtered level only moves after FILT_LEN consecutive samples disagree with it.
// Ports:
//   i_cclk   system clock
//   i_rstb   synchronous active-high reset
//   i_enc    raw asynchronous encoder input
//   o_level  synchronized (and optionally filtered) level
module quadrature_decoder_enc_input_cond #(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic i_cclk,
  input  logic i_rstb,
  input  logic i_enc,
  output logic o_level
);

  logic [1:0] r_sync;

  always_ff @(posedge i_cclk) begin
    if (i_rstb) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], i_enc};
    end
  end

`ifdef ENC_FILTER_EN
  localparam int unsigned CntW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic            r_filt;
  logic [CntW-1:0] r_cnt;

  // r_cnt counts consecutive samples that differ from r_filt; any agreeing sample restarts it.
  always_ff @(posedge i_cclk) begin
    if (i_rstb) begin
      r_filt <= 1'b0;
      r_cnt  <= '0;
    end else if (r_sync[1] != r_filt) begin
      if (r_cnt == CntW'(FILT_LEN - 1)) begin
        r_filt <= r_sync[1];
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign o_level = r_filt;
`else
  logic w_unused_filt;

  assign w_unused_filt = ^FILT_LEN;
  assign o_level       = r_sync[1];
`endif

endmodule

// File: rtl/quadrature_decoder.sv
// Incremental quadrature encoder decoder: 4x position, windowed velocity, direction and a
// sticky illegal-transition flag.
// Optional glitch filter on both channels is enabled by defining ENC_FILTER_EN.
// Ports:
//   i_cclk  system clock, all logic on the rising edge
//   i_rstb  synchronous active-high reset
//   io_bus  quadrature_decoder_if.slave:
//             enc_a/enc_b (async in), clear, err_clr (sync pulses in),
//             position, velocity, vel_valid, dir, err (out)
module quadrature_decoder
  import quadrature_decoder_pkg::*;
#(
  parameter int unsigned POS_WIDTH  = 16,
  parameter int unsigned VEL_WIDTH  = 8,
  parameter int unsigned VEL_WINDOW = 250000,
  parameter int unsigned FILT_LEN   = 4
) (
  input logic                 i_cclk,
  input logic                 i_rstb,
  quadrature_decoder_if.slave io_bus
);

  localparam int unsigned AccW = POS_WIDTH + 1;
  localparam int unsigned SumW = AccW + 1;
  localparam int unsigned WinW = $clog2(VEL_WINDOW);

  // Saturation bounds, held one bit wider than the accumulator so acc+step never overflows.
  localparam logic signed [SumW-1:0] AccMax = SumW'((64'd1 << (AccW - 1)) - 64'd1);
  localparam logic signed [SumW-1:0] AccMin = ~AccMax;
  localparam logic signed [SumW-1:0] VelMax = SumW'((64'd1 << (VEL_WIDTH - 1)) - 64'd1);
  localparam logic signed [SumW-1:0] VelMin = ~VelMax;

  logic w_a;
  logic w_b;

  quadrature_decoder_enc_input_cond #(
    .FILT_LEN (FILT_LEN)
  ) u_cond_a (
    .i_cclk  (i_cclk),
    .i_rstb  (i_rstb),
    .i_enc   (io_bus.enc_a),
    .o_level (w_a)
  );

  quadrature_decoder_enc_input_cond #(
    .FILT_LEN (FILT_LEN)
  ) u_cond_b (
    .i_cclk  (i_cclk),
    .i_rstb  (i_rstb),
    .i_enc   (io_bus.enc_b),
    .o_level (w_b)
  );

  logic [1:0] w_s;
  assign w_s = {w_a, w_b};

  // ---------------------------------------------------------------------------------------------
  // FSM: StInit lasts one cycle so the first sampled pair only seeds r_prev.
  // ---------------------------------------------------------------------------------------------
  qd_state_e r_state;
  qd_state_e w_state_d;
  logic [1:0] r_prev;
  step_t      w_step;
  logic       w_illegal;

  always_ff @(posedge i_cclk) begin
    if (i_rstb) begin
      r_state <= StInit;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_step    = STEP_NONE;
    w_illegal = 1'b0;
    unique case (r_state)
      StInit: begin
        w_state_d = StRun;
      end
      StRun: begin
        w_illegal = ((r_prev ^ w_s) == 2'b11);
        w_step    = gray_step(r_prev, w_s);
      end
      default: begin
        w_state_d = StInit;
      end
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------------------------
  logic [POS_WIDTH-1:0]   r_pos;
  logic                   r_dir;
  logic                   r_err;
  logic signed [AccW-1:0] r_acc;
  logic [WinW-1:0]        r_win;
  logic [VEL_WIDTH-1:0]   r_vel;
  logic                   r_vel_valid;

  logic [POS_WIDTH-1:0]   w_step_pos;
  logic signed [SumW-1:0] w_acc_sum;
  logic signed [AccW-1:0] w_acc_sat;
  logic [VEL_WIDTH-1:0]   w_vel_sat;
  logic                   w_win_tc;

  assign w_step_pos = {{(POS_WIDTH - 2){w_step[1]}}, w_step};
  assign w_acc_sum  = {r_acc[AccW-1], r_acc} + {{(SumW - 2){w_step[1]}}, w_step};
  assign w_win_tc   = (r_win == WinW'(VEL_WINDOW - 1));

  always_comb begin
    w_acc_sat = w_acc_sum[AccW-1:0];
    if (w_acc_sum > AccMax) begin
      w_acc_sat = AccMax[AccW-1:0];
    end else if (w_acc_sum < AccMin) begin
      w_acc_sat = AccMin[AccW-1:0];
    end

    w_vel_sat = w_acc_sum[VEL_WIDTH-1:0];
    if (w_acc_sum > VelMax) begin
      w_vel_sat = VelMax[VEL_WIDTH-1:0];
    end else if (w_acc_sum < VelMin) begin
      w_vel_sat = VelMin[VEL_WIDTH-1:0];
    end
  end

  always_ff @(posedge i_cclk) begin
    if (i_rstb) begin
      r_prev      <= 2'b00;
      r_pos       <= '0;
      r_dir       <= 1'b0;
      r_err       <= 1'b0;
      r_acc       <= '0;
      r_win       <= '0;
      r_vel       <= '0;
      r_vel_valid <= 1'b0;
    end else begin
      r_prev <= w_s;

      // clear wins over a coincident step; that step still reaches the velocity accumulator.
      if (io_bus.clear) begin
        r_pos <= '0;
      end else begin
        r_pos <= r_pos + w_step_pos;
      end

      if (w_step != STEP_NONE) begin
        r_dir <= (w_step == STEP_FWD);
      end

      // A new illegal transition outranks a clear request in the same cycle.
      if (w_illegal) begin
        r_err <= 1'b1;
      end else if (io_bus.err_clr) begin
        r_err <= 1'b0;
      end

      r_vel_valid <= w_win_tc;
      if (w_win_tc) begin
        r_win <= '0;
        r_acc <= '0;
        r_vel <= w_vel_sat;
      end else begin
        r_win <= r_win + 1'b1;
        r_acc <= w_acc_sat;
      end
    end
  end

  assign io_bus.position  = r_pos;
  assign io_bus.velocity  = r_vel;
  assign io_bus.vel_valid = r_vel_valid;
  assign io_bus.dir       = r_dir;
  assign io_bus.err       = r_err;

endmodule
